// File: rtl/lcd_spi_cmd_receiver.sv
`timescale 1ns/1ps
// lcd_spi_cmd_receiver
// Receiving end of the 4-wire LCD SPI link. Oversamples SCLK/MOSI/DC/CS on
// i_clk, deserializes mode-0 bytes and decodes them as an ILI9341-style
// command/parameter stream, tracking the power-control, VCOM, MADCTL and
// PIXFMT registers plus sleep/display state.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no parameter target; parameter bytes are ignored
// PARAM  | last command selected a register; parameters write it
module lcd_spi_cmd_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_dc,
  input  logic        i_cs,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic        o_byte_dc,
  output logic [7:0]  o_last_cmd,
  output logic [7:0]  o_pwctr1,
  output logic [7:0]  o_pwctr2,
  output logic [15:0] o_vmctr1,
  output logic [7:0]  o_vmctr2,
  output logic [7:0]  o_madctl,
  output logic [7:0]  o_pixfmt,
  output logic        o_sleep,
  output logic        o_disp_on,
  output logic [7:0]  o_cmd_count,
  output logic        o_frame_err,
  output logic        o_data_ignored
);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_PIXFMT  = 8'h3A;
  localparam logic [7:0] CMD_PWCTR1  = 8'hC0;
  localparam logic [7:0] CMD_PWCTR2  = 8'hC1;
  localparam logic [7:0] CMD_VMCTR1  = 8'hC5;
  localparam logic [7:0] CMD_VMCTR2  = 8'hC7;

  localparam logic [7:0]  RST_PWCTR1 = 8'h21;
  localparam logic [7:0]  RST_PWCTR2 = 8'h10;
  localparam logic [15:0] RST_VMCTR1 = 16'h3130;
  localparam logic [7:0]  RST_VMCTR2 = 8'hC0;
  localparam logic [7:0]  RST_MADCTL = 8'h00;
  localparam logic [7:0]  RST_PIXFMT = 8'h66;

  typedef enum logic {ST_IDLE, ST_PARAM} state_t;
  typedef enum logic [2:0] {
    TGT_PWCTR1, TGT_PWCTR2, TGT_VMCTR1, TGT_VMCTR2, TGT_MADCTL, TGT_PIXFMT
  } tgt_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, dc_sync_q, cs_sync_q;
  logic sclk_s, mosi_s, dc_s, cs_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, edge_act, byte_done;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, byte_d;
  logic [7:0] byte_q;
  logic byte_valid_q, byte_dc_q, frame_err_q;

  state_t state_q;
  tgt_t   tgt_q;
  logic [7:0]  last_cmd_q, cmd_count_q;
  logic [7:0]  pwctr1_q, pwctr2_q, vmctr2_q, madctl_q, pixfmt_q;
  logic [15:0] vmctr1_q;
  logic sleep_q, disp_on_q, data_ignored_q;

  // Input synchronizers; CS idles high so the link starts deselected
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      cs_sync_q   <= '1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], i_dc};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // An edge is still honoured in the cycle CS is first seen high, so a final
  // SCLK edge racing the CS rise completes its byte instead of faulting.
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign edge_act  = sclk_rise & ~(cs_s & cs_prev_q);
  assign byte_done = edge_act & (bit_cnt_q == 3'd7);
  assign byte_d    = {shift_q[7:1], mosi_s};

  // Serial front end: bit counter, shift register, byte capture, framing check
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_q       <= 8'h00;
      byte_dc_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      byte_valid_q <= byte_done;
      frame_err_q  <= 1'b0;
      if (byte_done) begin
        byte_q    <= byte_d;
        byte_dc_q <= dc_s;
      end
      if (cs_s) begin
        if (!byte_done && bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
        bit_cnt_q <= 3'd0;
      end else if (edge_act) begin
        shift_q[3'd7 - bit_cnt_q] <= mosi_s;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  // Command decoder: classify each completed byte and update controller state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      tgt_q          <= TGT_PWCTR1;
      last_cmd_q     <= 8'h00;
      cmd_count_q    <= 8'h00;
      pwctr1_q       <= RST_PWCTR1;
      pwctr2_q       <= RST_PWCTR2;
      vmctr1_q       <= RST_VMCTR1;
      vmctr2_q       <= RST_VMCTR2;
      madctl_q       <= RST_MADCTL;
      pixfmt_q       <= RST_PIXFMT;
      sleep_q        <= 1'b1;
      disp_on_q      <= 1'b0;
      data_ignored_q <= 1'b0;
    end else begin
      data_ignored_q <= 1'b0;
      if (byte_done) begin
        if (!dc_s) begin
          last_cmd_q <= byte_d;
          if (cmd_count_q != 8'hFF) cmd_count_q <= cmd_count_q + 8'd1;
          state_q <= ST_IDLE;
          case (byte_d)
            CMD_PWCTR1: begin state_q <= ST_PARAM; tgt_q <= TGT_PWCTR1; end
            CMD_PWCTR2: begin state_q <= ST_PARAM; tgt_q <= TGT_PWCTR2; end
            CMD_VMCTR1: begin state_q <= ST_PARAM; tgt_q <= TGT_VMCTR1; end
            CMD_VMCTR2: begin state_q <= ST_PARAM; tgt_q <= TGT_VMCTR2; end
            CMD_MADCTL: begin state_q <= ST_PARAM; tgt_q <= TGT_MADCTL; end
            CMD_PIXFMT: begin state_q <= ST_PARAM; tgt_q <= TGT_PIXFMT; end
            CMD_SWRESET: begin
              pwctr1_q  <= RST_PWCTR1;
              pwctr2_q  <= RST_PWCTR2;
              vmctr1_q  <= RST_VMCTR1;
              vmctr2_q  <= RST_VMCTR2;
              madctl_q  <= RST_MADCTL;
              pixfmt_q  <= RST_PIXFMT;
              sleep_q   <= 1'b1;
              disp_on_q <= 1'b0;
            end
            CMD_SLPOUT:  sleep_q   <= 1'b0;
            CMD_SLPIN:   sleep_q   <= 1'b1;
            CMD_DISPON:  disp_on_q <= 1'b1;
            CMD_DISPOFF: disp_on_q <= 1'b0;
            default: ;
          endcase
        end else if (state_q == ST_PARAM) begin
          case (tgt_q)
            TGT_PWCTR1: pwctr1_q <= byte_d;
            TGT_PWCTR2: pwctr2_q <= byte_d;
            TGT_VMCTR1: vmctr1_q <= {vmctr1_q[7:0], byte_d};
            TGT_VMCTR2: vmctr2_q <= byte_d;
            TGT_MADCTL: madctl_q <= byte_d;
            TGT_PIXFMT: pixfmt_q <= byte_d;
            default: ;
          endcase
        end else begin
          data_ignored_q <= 1'b1;
        end
      end
    end
  end

  assign o_byte         = byte_q;
  assign o_byte_valid   = byte_valid_q;
  assign o_byte_dc      = byte_dc_q;
  assign o_last_cmd     = last_cmd_q;
  assign o_pwctr1       = pwctr1_q;
  assign o_pwctr2       = pwctr2_q;
  assign o_vmctr1       = vmctr1_q;
  assign o_vmctr2       = vmctr2_q;
  assign o_madctl       = madctl_q;
  assign o_pixfmt       = pixfmt_q;
  assign o_sleep        = sleep_q;
  assign o_disp_on      = disp_on_q;
  assign o_cmd_count    = cmd_count_q;
  assign o_frame_err    = frame_err_q;
  assign o_data_ignored = data_ignored_q;

endmodule

// File: tb/tb_lcd_spi_cmd_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_spi_cmd_receiver: table-driven init sequence,
// hand-written corner cases, and randomized traffic against a byte-level model.
module tb_lcd_spi_cmd_receiver;

  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_sclk = 1'b0, i_mosi = 1'b0, i_dc = 1'b0, i_cs = 1'b1;
  logic [7:0]  o_byte, o_last_cmd, o_pwctr1, o_pwctr2, o_vmctr2, o_madctl, o_pixfmt, o_cmd_count;
  logic [15:0] o_vmctr1;
  logic o_byte_valid, o_byte_dc, o_sleep, o_disp_on, o_frame_err, o_data_ignored;

  lcd_spi_cmd_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_dc(i_dc), .i_cs(i_cs),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_byte_dc(o_byte_dc),
    .o_last_cmd(o_last_cmd), .o_pwctr1(o_pwctr1), .o_pwctr2(o_pwctr2),
    .o_vmctr1(o_vmctr1), .o_vmctr2(o_vmctr2), .o_madctl(o_madctl), .o_pixfmt(o_pixfmt),
    .o_sleep(o_sleep), .o_disp_on(o_disp_on), .o_cmd_count(o_cmd_count),
    .o_frame_err(o_frame_err), .o_data_ignored(o_data_ignored)
  );

  // ~27 MHz system clock
  always #18 i_clk = ~i_clk;

  localparam int HALF_1MHZ = 14;

  int n_vec = 0, n_err = 0;
  int valid_cnt = 0, ferr_cnt = 0, ign_cnt = 0;
  int exp_valid = 0, exp_ferr = 0, exp_ign = 0;

  // byte-level reference model
  logic [7:0]  m_byte, m_last, m_pw1, m_pw2, m_vm2, m_mad, m_pix;
  logic [15:0] m_vm1;
  logic        m_bdc, m_sleep, m_disp;
  int          m_cnt, m_target;

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    int          sel;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[16];

  // pulse counters, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_byte_valid)   valid_cnt++;
    if (o_frame_err)    ferr_cnt++;
    if (o_data_ignored) ign_cnt++;
  end

  task automatic chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  function automatic void model_regs_default();
    m_pw1 = 8'h21; m_pw2 = 8'h10; m_vm1 = 16'h3130; m_vm2 = 8'hC0;
    m_mad = 8'h00; m_pix = 8'h66; m_sleep = 1'b1; m_disp = 1'b0;
  endfunction

  function automatic void model_reset();
    m_byte = 8'h00; m_bdc = 1'b0; m_last = 8'h00; m_cnt = 0; m_target = 0;
    model_regs_default();
  endfunction

  // target is remembered as the selecting command code (0 = none)
  function automatic void model_byte(input logic dc, input logic [7:0] b);
    m_byte = b; m_bdc = dc; exp_valid++;
    if (!dc) begin
      m_last = b;
      if (m_cnt < 255) m_cnt++;
      m_target = 0;
      case (b)
        8'hC0, 8'hC1, 8'hC5, 8'hC7, 8'h36, 8'h3A: m_target = int'(b);
        8'h01: model_regs_default();
        8'h11: m_sleep = 1'b0;
        8'h10: m_sleep = 1'b1;
        8'h29: m_disp = 1'b1;
        8'h28: m_disp = 1'b0;
        default: ;
      endcase
    end else if (m_target == 0) begin
      exp_ign++;
    end else begin
      case (m_target)
        'hC0: m_pw1 = b;
        'hC1: m_pw2 = b;
        'hC5: m_vm1 = {m_vm1[7:0], b};
        'hC7: m_vm2 = b;
        'h36: m_mad = b;
        'h3A: m_pix = b;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [15:0] dut_out(input int sel);
    case (sel)
      0: return {8'h00, o_last_cmd};
      1: return {8'h00, o_pwctr1};
      2: return {8'h00, o_pwctr2};
      3: return o_vmctr1;
      4: return {8'h00, o_vmctr2};
      5: return {8'h00, o_madctl};
      6: return {8'h00, o_pixfmt};
      7: return {15'h0, o_sleep};
      default: return {15'h0, o_disp_on};
    endcase
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
    i_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      i_mosi = b[7-i];
      wclk(half);
      i_sclk = 1'b1;
      wclk(half);
      i_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b, input int half);
    i_dc = dc;
    send_bits(b, 8, half);
    model_byte(dc, b);
    wclk(6);
  endtask

  task automatic cs_high();
    i_cs = 1'b1;
    wclk(6);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    wclk(3);
    i_rst = 1'b0;
    model_reset();
    wclk(2);
  endtask

  task automatic check_all(input string tag);
    chk(tag, "byte",     {8'h00, o_byte},      {8'h00, m_byte});
    chk(tag, "byte_dc",  {15'h0, o_byte_dc},   {15'h0, m_bdc});
    chk(tag, "last_cmd", {8'h00, o_last_cmd},  {8'h00, m_last});
    chk(tag, "cmd_cnt",  {8'h00, o_cmd_count}, 16'(m_cnt));
    chk(tag, "pwctr1",   {8'h00, o_pwctr1},    {8'h00, m_pw1});
    chk(tag, "pwctr2",   {8'h00, o_pwctr2},    {8'h00, m_pw2});
    chk(tag, "vmctr1",   o_vmctr1,             m_vm1);
    chk(tag, "vmctr2",   {8'h00, o_vmctr2},    {8'h00, m_vm2});
    chk(tag, "madctl",   {8'h00, o_madctl},    {8'h00, m_mad});
    chk(tag, "pixfmt",   {8'h00, o_pixfmt},    {8'h00, m_pix});
    chk(tag, "sleep",    {15'h0, o_sleep},     {15'h0, m_sleep});
    chk(tag, "disp_on",  {15'h0, o_disp_on},   {15'h0, m_disp});
    chk(tag, "n_valid",  16'(valid_cnt),       16'(exp_valid));
    chk(tag, "n_ferr",   16'(ferr_cnt),        16'(exp_ferr));
    chk(tag, "n_ignored",16'(ign_cnt),         16'(exp_ign));
  endtask

  initial begin
    logic [7:0] cmds[12];
    int v0, f0, g0, r, half, nb;
    logic [7:0] b;

    tbl[0]  = '{1'b0, 8'h01, 0, 16'h0001};
    tbl[1]  = '{1'b0, 8'hC0, 0, 16'h00C0};
    tbl[2]  = '{1'b1, 8'h23, 1, 16'h0023};
    tbl[3]  = '{1'b0, 8'hC1, 0, 16'h00C1};
    tbl[4]  = '{1'b1, 8'h10, 2, 16'h0010};
    tbl[5]  = '{1'b0, 8'hC5, 0, 16'h00C5};
    tbl[6]  = '{1'b1, 8'h3E, 3, 16'h303E};
    tbl[7]  = '{1'b1, 8'h28, 3, 16'h3E28};
    tbl[8]  = '{1'b0, 8'hC7, 0, 16'h00C7};
    tbl[9]  = '{1'b1, 8'h86, 4, 16'h0086};
    tbl[10] = '{1'b0, 8'h36, 0, 16'h0036};
    tbl[11] = '{1'b1, 8'h88, 5, 16'h0088};
    tbl[12] = '{1'b0, 8'h3A, 0, 16'h003A};
    tbl[13] = '{1'b1, 8'h55, 6, 16'h0055};
    tbl[14] = '{1'b0, 8'h11, 7, 16'h0000};
    tbl[15] = '{1'b0, 8'h29, 8, 16'h0001};

    cmds = '{8'hC0, 8'hC1, 8'hC5, 8'hC7, 8'h36, 8'h3A, 8'h01, 8'h11, 8'h10, 8'h29, 8'h28, 8'h00};

    // reset values, sampled while reset is held
    model_reset();
    wclk(4);
    chk("rst", "pwctr1", {8'h00, o_pwctr1}, 16'h0021);
    chk("rst", "pwctr2", {8'h00, o_pwctr2}, 16'h0010);
    chk("rst", "vmctr1", o_vmctr1, 16'h3130);
    chk("rst", "vmctr2", {8'h00, o_vmctr2}, 16'h00C0);
    chk("rst", "pixfmt", {8'h00, o_pixfmt}, 16'h0066);
    chk("rst", "sleep",  {15'h0, o_sleep}, 16'h0001);
    chk("rst", "disp",   {15'h0, o_disp_on}, 16'h0000);
    chk("rst", "cmdcnt", {8'h00, o_cmd_count}, 16'h0000);
    i_rst = 1'b0;
    wclk(2);
    check_all("rst");

    // one command + one parameter at 1 MHz SCLK
    v0 = valid_cnt;
    send_byte(1'b0, 8'hC0, HALF_1MHZ);
    send_byte(1'b1, 8'h23, HALF_1MHZ);
    chk("tp1", "valid_pulses", 16'(valid_cnt - v0), 16'd2);
    chk("tp1", "last_cmd", {8'h00, o_last_cmd}, 16'h00C0);
    chk("tp1", "pwctr1", {8'h00, o_pwctr1}, 16'h0023);
    chk("tp1", "cmd_cnt", {8'h00, o_cmd_count}, 16'h0001);
    check_all("tp1");

    // full init sequence, table-driven
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(tbl[i].dc, tbl[i].data, HALF_1MHZ);
      chk($sformatf("init%0d", i), "sel_out", dut_out(tbl[i].sel), tbl[i].exp);
    end
    chk("init", "cmd_cnt", {8'h00, o_cmd_count}, 16'h0009);
    check_all("init");

    // last parameter wins, no ignore pulse
    g0 = ign_cnt;
    send_byte(1'b0, 8'h3A, 5);
    send_byte(1'b1, 8'h00, 5);
    send_byte(1'b1, 8'h55, 5);
    chk("pix", "pixfmt", {8'h00, o_pixfmt}, 16'h0055);
    chk("pix", "ignored", 16'(ign_cnt - g0), 16'd0);

    // partial byte aborted by CS
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bits(8'hA5, 5, 5);
    cs_high();
    exp_ferr++;
    chk("abort", "ferr", 16'(ferr_cnt - f0), 16'd1);
    chk("abort", "no_byte", 16'(valid_cnt - v0), 16'd0);
    send_byte(1'b0, 8'h36, 5);
    send_byte(1'b1, 8'h48, 5);
    chk("abort", "madctl", {8'h00, o_madctl}, 16'h0048);
    cs_high();
    check_all("abort");

    // parameter with no target, then SWRESET
    g0 = ign_cnt;
    send_byte(1'b0, 8'h29, 5);
    send_byte(1'b1, 8'hAA, 5);
    chk("ign", "ignored", 16'(ign_cnt - g0), 16'd1);
    check_all("ign");
    send_byte(1'b0, 8'h01, 5);
    chk("swrst", "pwctr1", {8'h00, o_pwctr1}, 16'h0021);
    chk("swrst", "vmctr1", o_vmctr1, 16'h3130);
    chk("swrst", "madctl", {8'h00, o_madctl}, 16'h0000);
    chk("swrst", "pixfmt", {8'h00, o_pixfmt}, 16'h0066);
    chk("swrst", "sleep", {15'h0, o_sleep}, 16'h0001);
    chk("swrst", "disp", {15'h0, o_disp_on}, 16'h0000);
    chk("swrst", "last_cmd", {8'h00, o_last_cmd}, 16'h0001);
    check_all("swrst");

    // reset mid-byte
    f0 = ferr_cnt;
    send_bits(8'hFF, 4, 5);
    do_reset();
    send_byte(1'b0, 8'h11, 5);
    chk("rstmid", "sleep", {15'h0, o_sleep}, 16'h0000);
    chk("rstmid", "cmd_cnt", {8'h00, o_cmd_count}, 16'h0001);
    cs_high();
    chk("rstmid", "ferr", 16'(ferr_cnt - f0), 16'd0);
    check_all("rstmid");

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      half = $urandom_range(3, 6);
      if (r <= 3) begin
        b = cmds[$urandom_range(0, 11)];
        if (b == 8'h00) b = 8'($urandom);
        send_byte(1'b0, b, half);
      end else if (r <= 7) begin
        send_byte(1'b1, 8'($urandom), half);
      end else if (r == 8) begin
        nb = $urandom_range(1, 7);
        i_dc = 1'($urandom);
        send_bits(8'($urandom), nb, half);
        cs_high();
        exp_ferr++;
      end else begin
        cs_high();
      end
      check_all($sformatf("rnd%0d", k));
    end

    // command counter saturation
    for (int k = 0; k < 260; k++) send_byte(1'b0, 8'h00, 3);
    chk("sat", "cmd_cnt", {8'h00, o_cmd_count}, 16'h00FF);
    check_all("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
